mix_phase_ctrl: RTL



---
 rtl/mix_phase_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mix_phase_ctrl.sv
// Receive-mixer phase-word controller: staged writes, pairwise commit, settle gating.
// Define FREQ_READBACK_EN to add the rd_addr/rd_data register readback port.
module mix_phase_ctrl #(
    parameter int NRX    = 4,
    parameter int SETTLE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_addr,
    input  logic [31:0]       cmd_data,
    output logic [32*NRX-1:0] phi,
    output logic [NRX-1:0]    rx_valid,
`ifdef FREQ_READBACK_EN
    input  logic [5:0]        rd_addr,
    output logic [31:0]       rd_data,
`endif
    output logic              busy
);

    localparam int NP = NRX / 2;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW = $clog2(SETTLE);
    localparam logic [PW-1:0] LASTP = PW'(NP - 1);
    localparam logic [CW-1:0] CNT0  = CW'(SETTLE - 1);
    localparam logic [4:0]    NRX5  = 5'(NRX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t         r_state, w_state_nx;
    logic [PW-1:0]  r_p, w_p_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [NRX-1:0] r_mask, r_pend, r_rxv;
    logic [4:0]     r_nrx, w_nrx;
    logic           r_busy;
    logic [31:0]    r_stage [NRX];
    logic [31:0]    r_phi   [NRX];
    logic           w_acc, w_commit;

    assign cmd_ready = (r_state != S_COMMIT);
    assign w_acc     = cmd_valid & cmd_ready;
    assign w_commit  = w_acc & (cmd_addr == 6'h3F) & (|cmd_data[NRX-1:0]);

    always_comb begin
        w_nrx = cmd_data[4:0];
        if (cmd_data[4:0] == 5'd0)
            w_nrx = 5'd1;
        else if (cmd_data[4:0] > NRX5)
            w_nrx = NRX5;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_SETTLE;
            r_p     <= '0;
            r_cnt   <= CNT0;
        end else begin
            r_state <= w_state_nx;
            r_p     <= w_p_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A commit arriving during settle restarts the whole sequence.
    always_comb begin
        w_state_nx = r_state;
        w_p_nx     = r_p;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    w_state_nx = S_COMMIT;
                    w_p_nx     = '0;
                end
            end
            S_COMMIT: begin
                if (r_p == LASTP) begin
                    w_state_nx = S_SETTLE;
                    w_cnt_nx   = CNT0;
                end else begin
                    w_p_nx = r_p + 1'b1;
                end
            end
            S_SETTLE: begin
                if (w_commit) begin
                    w_state_nx = S_COMMIT;
                    w_p_nx     = '0;
                end else if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NRX; n++) begin
                r_stage[n] <= '0;
                r_phi[n]   <= '0;
            end
            r_nrx  <= NRX5;
            r_mask <= '0;
            r_pend <= '1;
            r_rxv  <= '0;
            r_busy <= 1'b1;
        end else begin
            for (int n = 0; n < NRX; n++) begin
                if (w_acc && cmd_addr == 6'(n))
                    r_stage[n] <= cmd_data;
                if (r_state == S_COMMIT && r_mask[n] && r_p == PW'(n / 2))
                    r_phi[n] <= r_stage[n];
                r_rxv[n] <= ~r_pend[n] & (5'(n) < r_nrx);
            end
            if (w_acc && cmd_addr == 6'h3E)
                r_nrx <= w_nrx;
            if (w_commit) begin
                r_mask <= cmd_data[NRX-1:0];
                r_pend <= r_pend | cmd_data[NRX-1:0];
            end else if (r_state == S_SETTLE && r_cnt == '0) begin
                r_pend <= '0;
            end
            r_busy <= (r_state != S_IDLE);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NRX; g++) begin : g_phi
            assign phi[32*g +: 32] = r_phi[g];
        end
    endgenerate

    assign rx_valid = r_rxv;
    assign busy     = r_busy;

`ifdef FREQ_READBACK_EN
    logic [31:0] r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0;
        end else begin
            r_rd <= '0;
            for (int n = 0; n < NRX; n++)
                if (rd_addr == 6'(n))
                    r_rd <= r_phi[n];
            if (rd_addr == 6'h3E)
                r_rd <= 32'(r_nrx);
            if (rd_addr == 6'h3F)
                r_rd <= {r_state, 14'b0, 16'(r_pend)};
        end
    end

    assign rd_data = r_rd;
`endif

endmodule
